fifo_scoreboard: RTL and testbench

Self-checking monitor that sits beside the block-RAM FIFO. It observes the same wr/rd/wr_data stimulus the FIFO receives, plus the FIFO's rd_data/full/empty responses. It keeps a cycle-accurate shadow queue and flags every data or flag mismatch. It is synthesizable, so it runs on-board and in simulation.

---
 rtl/fifo_scoreboard_pkg.sv | 20 ++
 rtl/fifo_scoreboard_if.sv | 15 +
 rtl/fifo_ref_model.sv | 68 ++++++
 rtl/fifo_scoreboard.sv | 123 ++++++++++++
 tb/tb_fifo_scoreboard.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_scoreboard_pkg.sv
// Shared types and constants for the FIFO scoreboard: checker states,
// err_code bit positions and a saturating counter helper.
package fifo_chk_pkg;

   typedef enum logic [1:0] {
      ARM   = 2'd0,
      CHECK = 2'd1,
      HALT  = 2'd2
   } chk_state_e;

   localparam int ERR_DATA  = 0;
   localparam int ERR_EMPTY = 1;
   localparam int ERR_FULL  = 2;
   localparam int ERR_W     = 3;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fifo_scoreboard_if.sv
// Observation bundle between the FIFO under test and its scoreboard:
// the stimulus the FIFO sees plus the FIFO's responses.
interface fifo_scoreboard_if #(
   parameter int B = 8
);
   logic         wr;
   logic         rd;
   logic [B-1:0] wr_data;
   logic [B-1:0] rd_data;
   logic         full;
   logic         empty;

   modport master (output wr, rd, wr_data, rd_data, full, empty);
   modport slave  (input  wr, rd, wr_data, rd_data, full, empty);
endinterface

// File: rtl/fifo_ref_model.sv
// Cycle-accurate shadow queue for the FIFO scoreboard. Pointers carry one
// extra MSB so full and empty are distinguishable when the indices match.
module fifo_ref_model #(
   parameter int B = 8,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_i,
   input  logic         rd_i,
   input  logic [B-1:0] wr_data_i,
   output logic [B-1:0] head_o,
   output logic         model_full_o,
   output logic         model_empty_o,
   output logic         pop_o,
   output logic [W:0]   occupancy_o
);

   localparam int DEPTH = 2**W;

   logic [B-1:0] mem_q [DEPTH];
   logic [W:0]   w_ptr_q, w_ptr_d;
   logic [W:0]   r_ptr_q, r_ptr_d;
   logic [W:0]   occ_q, occ_d;
   logic         push;
   logic         pop;
   logic         model_full;
   logic         model_empty;

   assign model_empty = (w_ptr_q == r_ptr_q);
   assign model_full  = (w_ptr_q[W] != r_ptr_q[W]) &&
                        (w_ptr_q[W-1:0] == r_ptr_q[W-1:0]);

   // A simultaneous read frees the slot, so a full queue still takes the write.
   assign pop  = rd_i && !model_empty;
   assign push = wr_i && (!model_full || rd_i);

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      if (push) w_ptr_d = w_ptr_q + 1'b1;
      if (pop)  r_ptr_d = r_ptr_q + 1'b1;
      occ_d = w_ptr_d - r_ptr_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         occ_q   <= '0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         occ_q   <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[w_ptr_q[W-1:0]] <= wr_data_i;
   end

   assign head_o        = mem_q[r_ptr_q[W-1:0]];
   assign model_full_o  = model_full;
   assign model_empty_o = model_empty;
   assign pop_o         = pop;
   assign occupancy_o   = occ_q;

endmodule

// File: rtl/fifo_scoreboard.sv
// Synthesizable monitor for the block-RAM FIFO: shadows every accepted
// transfer and flags data/flag mismatches one cycle after they are seen.
//
//   state | meaning
//   ARM   | first cycle after reset, model tracks but nothing is checked
//   CHECK | normal checking, errors counted
//   HALT  | err_count reached MAX_ERR; fail held, counting frozen until rst
module fifo_scoreboard
   import fifo_chk_pkg::*;
#(
   parameter int B       = 8,
   parameter int W       = 4,
   parameter int MAX_ERR = 255
) (
   input  logic              clk,
   input  logic              rst,
   fifo_scoreboard_if.slave  mon,
   output logic              err,
   output logic [ERR_W-1:0]  err_code,
   output logic [B-1:0]      exp_data,
   output logic [15:0]       err_count,
   output logic              fail,
   output logic [W:0]        occupancy
);

   localparam logic [1:0]  S_ARM     = ARM;
   localparam logic [1:0]  S_CHECK   = CHECK;
   localparam logic [1:0]  S_HALT    = HALT;
   localparam logic [15:0] MAX_ERR_C = 16'(MAX_ERR);

   logic [B-1:0]     head;
   logic             model_full;
   logic             model_empty;
   logic             pop;
   logic [W:0]       occ;

   logic [1:0]       state_q, state_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_code_q, err_code_d;
   logic [B-1:0]     exp_data_q, exp_data_d;
   logic [15:0]      err_count_q, err_count_d;
   logic             fail_q, fail_d;
   logic [ERR_W-1:0] mis;

   fifo_ref_model #(
      .B (B),
      .W (W)
   ) u_ref_model (
      .clk           (clk),
      .rst           (rst),
      .wr_i          (mon.wr),
      .rd_i          (mon.rd),
      .wr_data_i     (mon.wr_data),
      .head_o        (head),
      .model_full_o  (model_full),
      .model_empty_o (model_empty),
      .pop_o         (pop),
      .occupancy_o   (occ)
   );

   // A read ignored by an empty model is never data-checked.
   always_comb begin
      mis            = '0;
      mis[ERR_DATA]  = pop && (mon.rd_data != head);
      mis[ERR_EMPTY] = (mon.empty != model_empty);
      mis[ERR_FULL]  = (mon.full != model_full);
   end

   always_comb begin
      state_d     = state_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      exp_data_d  = exp_data_q;
      err_count_d = err_count_q;
      case (state_q)
         S_ARM: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (|mis) begin
               err_d       = 1'b1;
               err_code_d  = mis;
               exp_data_d  = model_empty ? '0 : head;
               err_count_d = sat_inc16(err_count_q);
               if (err_count_d >= MAX_ERR_C) state_d = S_HALT;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_ARM;
         end
      endcase
      fail_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ARM;
         err_q       <= 1'b0;
         err_code_q  <= '0;
         exp_data_q  <= '0;
         err_count_q <= '0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         exp_data_q  <= exp_data_d;
         err_count_q <= err_count_d;
         fail_q      <= fail_d;
      end
   end

   assign err       = err_q;
   assign err_code  = err_code_q;
   assign exp_data  = exp_data_q;
   assign err_count = err_count_q;
   assign fail      = fail_q;
   assign occupancy = occ;

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Directed bench for fifo_scoreboard: acts as a correct FIFO for the clean
// scenarios and drives hand-made faulty responses for the error scenarios.
module tb_fifo_scoreboard;

   logic        clk;
   logic        rst;
   logic        err;
   logic [2:0]  err_code;
   logic [7:0]  exp_data;
   logic [15:0] err_count;
   logic        fail;
   logic [4:0]  occupancy;

   int checks;
   int errors;
   logic [7:0] q [$];

   fifo_scoreboard_if #(.B(8)) mon_if ();

   fifo_scoreboard #(
      .B       (8),
      .W       (4),
      .MAX_ERR (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mon       (mon_if),
      .err       (err),
      .err_code  (err_code),
      .exp_data  (exp_data),
      .err_count (err_count),
      .fail      (fail),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic r, input logic [7:0] wd,
                      input logic [7:0] rdd, input logic f, input logic e);
      mon_if.wr      = w;
      mon_if.rd      = r;
      mon_if.wr_data = wd;
      mon_if.rd_data = rdd;
      mon_if.full    = f;
      mon_if.empty   = e;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Behaves as a correct first-word-fall-through FIFO of depth 16.
   task automatic fifo_step(input logic w, input logic r, input logic [7:0] wd);
      logic       e;
      logic       f;
      logic [7:0] h;
      e = (q.size() == 0);
      f = (q.size() == 16);
      h = e ? 8'h00 : q[0];
      cyc(w, r, wd, h, f, e);
      if (r && !e) void'(q.pop_front());
      if (w && (!f || r)) q.push_back(wd);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      rst = 1'b0;
      q.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      mon_if.wr = 1'b0; mon_if.rd = 1'b0; mon_if.wr_data = '0;
      mon_if.rd_data = '0; mon_if.full = 1'b0; mon_if.empty = 1'b1;
      @(negedge clk);

      do_reset();
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_exp", exp_data, 0);
      chk("rst_cnt", err_count, 0);
      chk("rst_fail", fail, 0);
      chk("rst_occ", occupancy, 0);

      // 1: eight writes then ten reads against a correct FIFO
      for (int i = 0; i < 8; i++) fifo_step(1'b1, 1'b0, 8'h41 + 8'(i));
      chk("t1_occ8", occupancy, 8);
      for (int i = 0; i < 10; i++) begin
         fifo_step(1'b0, 1'b1, 8'h00);
         chk($sformatf("t1_err_rd%0d", i), err, 0);
      end
      chk("t1_occ0", occupancy, 0);
      chk("t1_cnt", err_count, 0);

      // 2: overfill with 18 writes, then drain with 20 reads
      do_reset();
      for (int i = 0; i < 18; i++) begin
         fifo_step(1'b1, 1'b0, 8'h49 + 8'(i));
         if (i == 15) chk("t2_occ16", occupancy, 16);
      end
      chk("t2_occ_sat", occupancy, 16);
      chk("t2_err_wr", err_count, 0);
      for (int i = 0; i < 20; i++) begin
         fifo_step(1'b0, 1'b1, 8'h00);
         chk($sformatf("t2_err_rd%0d", i), err, 0);
      end
      chk("t2_occ0", occupancy, 0);
      chk("t2_cnt", err_count, 0);

      // 3: wrong head data on a pop
      do_reset();
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b1);
      chk("t3_occ1", occupancy, 1);
      chk("t3_no_err", err, 0);
      cyc(1'b0, 1'b1, 8'h00, 8'h42, 1'b0, 1'b0);
      chk("t3_err", err, 1);
      chk("t3_code", err_code, 3'b001);
      chk("t3_exp", exp_data, 8'h41);
      chk("t3_cnt", err_count, 1);
      chk("t3_occ0", occupancy, 0);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      chk("t3_pulse", err, 0);
      chk("t3_cnt_hold", err_count, 1);

      // 4a: empty flag wrong on an empty queue
      do_reset();
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t4_empty_err", err, 1);
      chk("t4_empty_code", err_code, 3'b010);
      chk("t4_empty_cnt", err_count, 1);

      // 4b: full flag wrong with 16 entries
      do_reset();
      for (int i = 0; i < 16; i++) fifo_step(1'b1, 1'b0, 8'hA0 + 8'(i));
      chk("t4_fill_clean", err_count, 0);
      cyc(1'b0, 1'b0, 8'h00, 8'hA0, 1'b0, 1'b0);
      chk("t4_full_err", err, 1);
      chk("t4_full_code", err_code, 3'b100);
      chk("t4_full_exp", exp_data, 8'hA0);
      chk("t4_full_occ", occupancy, 16);

      // 5a: simultaneous wr/rd on an empty queue pushes only, no data check
      do_reset();
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 8'h09, 8'hFF, 1'b0, 1'b1);
      chk("t5_empty_wrrd_err", err, 0);
      chk("t5_empty_wrrd_occ", occupancy, 1);

      // 5b: simultaneous wr/rd on a full queue, head checked, then drain across wrap
      do_reset();
      for (int i = 0; i < 16; i++) fifo_step(1'b1, 1'b0, 8'h10 + 8'(i));
      cyc(1'b1, 1'b1, 8'h77, 8'h55, 1'b1, 1'b0);
      chk("t5_full_wrrd_err", err, 1);
      chk("t5_full_wrrd_code", err_code, 3'b001);
      chk("t5_full_wrrd_exp", exp_data, 8'h10);
      chk("t5_full_wrrd_occ", occupancy, 16);
      cyc(1'b0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0);
      chk("t5_pop_err", err, 0);
      chk("t5_pop_occ", occupancy, 15);
      for (int i = 2; i < 16; i++) cyc(1'b0, 1'b1, 8'h00, 8'h10 + 8'(i), 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b0);
      chk("t5_drain_cnt", err_count, 1);
      chk("t5_drain_occ", occupancy, 0);

      // 6: persistent mismatch reaches MAX_ERR=3 and halts
      do_reset();
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_cnt1", err_count, 1);
      chk("t6_fail1", fail, 0);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_cnt2", err_count, 2);
      chk("t6_fail2", fail, 0);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_cnt3", err_count, 3);
      chk("t6_fail3", fail, 1);
      chk("t6_err3", err, 1);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_cnt_frozen", err_count, 3);
      chk("t6_fail_sticky", fail, 1);
      do_reset();
      chk("t6_rst_err", err, 0);
      chk("t6_rst_code", err_code, 0);
      chk("t6_rst_exp", exp_data, 0);
      chk("t6_rst_cnt", err_count, 0);
      chk("t6_rst_fail", fail, 0);
      chk("t6_rst_occ", occupancy, 0);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_arm_nochk", err, 0);
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("t6_check_err", err, 1);
      chk("t6_check_cnt", err_count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
